// File: rtl/if_fetch_pkg.sv
// Shared constants and the IF/ID entry type for the instruction fetch stage.
package if_fetch_pkg;

  localparam int unsigned INST_ADDR_W = 32;
  localparam int unsigned INST_W      = 32;

  localparam logic [INST_W-1:0]      ZERO_WORD    = 32'h0000_0000;
  localparam logic [INST_ADDR_W-1:0] PC_STEP      = 32'h0000_0004;
  localparam logic                   INST_VALID   = 1'b1;
  localparam logic                   INST_INVALID = 1'b0;

  typedef struct packed {
    logic [INST_ADDR_W-1:0] pc;
    logic [INST_W-1:0]      inst;
    logic                   valid;
  } fetch_entry_t;

endpackage

// File: rtl/if_hold_buf.sv
// One-entry holding register for a response that arrives while the decoder is stalled.
module if_hold_buf
  import if_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic         take,
  input  fetch_entry_t entry_i,
  output fetch_entry_t entry_o
);

  fetch_entry_t entry_d, entry_q;

  always_comb begin
    entry_d = entry_q;
    if (load) entry_d = entry_i;
    if (clear || take) entry_d.valid = INST_INVALID;
  end

  always_ff @(posedge clk) begin
    if (rst) entry_q <= '{pc: '0, inst: ZERO_WORD, valid: INST_INVALID};
    else     entry_q <= entry_d;
  end

  assign entry_o = entry_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: owns the PC, runs a single-outstanding req/gnt/rvalid fetch,
// and feeds the registered IF/ID boundary with stall and branch-redirect handling.
//
// state   | meaning
// IDLE    | one cycle after reset before the first request
// REQ     | request driven at fetch_pc, waiting for gnt
// WAIT    | request granted, waiting for rvalid (drop_q discards a stale response)
// HOLD    | response parked in the hold buffer until the stall releases
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [INST_ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_i,
  input  logic                   branch_flag_i,
  input  logic [INST_ADDR_W-1:0] branch_target_i,
  output logic                   imem_req_o,
  output logic [INST_ADDR_W-1:0] imem_addr_o,
  input  logic                   imem_gnt_i,
  input  logic                   imem_rvalid_i,
  input  logic [INST_W-1:0]      imem_rdata_i,
  output logic [INST_ADDR_W-1:0] pc_o,
  output logic [INST_W-1:0]      inst_o,
  output logic                   inst_valid_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_HOLD} fetch_state_e;

  fetch_state_e           state_d, state_q;
  logic [INST_ADDR_W-1:0] fetch_pc_d, fetch_pc_q;
  logic                   drop_d, drop_q;
  fetch_entry_t           out_d, out_q;
  fetch_entry_t           hb_in, hb_out;
  logic                   hb_load, hb_clear, hb_take;

  if_hold_buf u_hold_buf (
    .clk     (clk),
    .rst     (rst),
    .load    (hb_load),
    .clear   (hb_clear),
    .take    (hb_take),
    .entry_i (hb_in),
    .entry_o (hb_out)
  );

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q;
    out_d      = out_q;
    hb_load    = 1'b0;
    hb_clear   = 1'b0;
    hb_take    = 1'b0;
    hb_in      = '{pc: fetch_pc_q, inst: imem_rdata_i, valid: INST_VALID};

    // An unstalled decoder consumes the current word; it reverts to a NOP.
    if (!stall_i) out_d = '{pc: out_q.pc, inst: ZERO_WORD, valid: INST_INVALID};

    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        if (imem_gnt_i) begin
          state_d = ST_WAIT;
          drop_d  = branch_flag_i;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid_i) begin
          state_d = ST_REQ;
          drop_d  = 1'b0;
          if (!(drop_q || branch_flag_i)) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
            if (stall_i && out_q.valid) begin
              hb_load = 1'b1;
              state_d = ST_HOLD;
            end else begin
              out_d = hb_in;
            end
          end
        end else if (branch_flag_i) begin
          drop_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (!stall_i) begin
          out_d   = hb_out;
          hb_take = 1'b1;
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Redirect overrides everything except reset, stalled or not.
    if (branch_flag_i) begin
      fetch_pc_d  = branch_target_i;
      out_d.inst  = ZERO_WORD;
      out_d.valid = INST_INVALID;
      hb_clear    = 1'b1;
      if (state_q == ST_HOLD || state_q == ST_IDLE) state_d = ST_REQ;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      drop_q     <= 1'b0;
      out_q      <= '{pc: '0, inst: ZERO_WORD, valid: INST_INVALID};
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      drop_q     <= drop_d;
      out_q      <= out_d;
    end
  end

  assign imem_req_o   = (state_q == ST_REQ);
  assign imem_addr_o  = fetch_pc_q;
  assign pc_o         = out_q.pc;
  assign inst_o       = out_q.inst;
  assign inst_valid_o = out_q.valid;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: zero-wait fetch, stall/hold, branch cases, reset and wrap.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;

  int n_checks = 0;
  int n_fail   = 0;

  if_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_gnt_i      (imem_gnt_i),
    .imem_rvalid_i   (imem_rvalid_i),
    .imem_rdata_i    (imem_rdata_i),
    .pc_o            (pc_o),
    .inst_o          (inst_o),
    .inst_valid_o    (inst_valid_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] dat(input logic [31:0] a);
    return 32'hA500_0000 | a;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] inst);
    chk({tag, "_valid"}, {31'd0, inst_valid_o}, {31'd0, v});
    chk({tag, "_pc"}, pc_o, pc);
    chk({tag, "_inst"}, inst_o, inst);
  endtask

  // Zero-wait fetch of address a starting from REQ; leaves the DUT in REQ at a+4.
  task automatic do_fetch(input logic [31:0] a);
    logic [31:0] nxt;
    nxt = a + 32'd4;
    chk("fetch_req", {31'd0, imem_req_o}, 32'd1);
    chk("fetch_addr", imem_addr_o, a);
    imem_gnt_i = 1'b1;
    step();
    imem_gnt_i = 1'b0;
    chk("fetch_wait_req", {31'd0, imem_req_o}, 32'd0);
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = dat(a);
    step();
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    chk_out("fetch_out", 1'b1, a, dat(a));
    chk("fetch_next_req", {31'd0, imem_req_o}, 32'd1);
    chk("fetch_next_addr", imem_addr_o, nxt);
  endtask

  initial begin
    rst = 1'b1; stall_i = 1'b0; branch_flag_i = 1'b0; branch_target_i = 32'h0;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
    step();
    step();
    chk_out("rst", 1'b0, 32'h0, 32'h0);
    chk("rst_req", {31'd0, imem_req_o}, 32'd0);
    chk("rst_addr", imem_addr_o, 32'h0);

    // IDLE one cycle, then REQ
    rst = 1'b0;
    chk("idle_req", {31'd0, imem_req_o}, 32'd0);
    step();

    do_fetch(32'h0);
    do_fetch(32'h4);

    // Stall with the fetch of 8 in flight
    stall_i = 1'b1;
    imem_gnt_i = 1'b1;
    step();
    imem_gnt_i = 1'b0;
    chk_out("stall_wait", 1'b1, 32'h4, dat(32'h4));
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = dat(32'h8);
    step();
    imem_rvalid_i = 1'b0;
    chk_out("stall_hold", 1'b1, 32'h4, dat(32'h4));
    chk("hold_req", {31'd0, imem_req_o}, 32'd0);
    step();
    chk("hold_req2", {31'd0, imem_req_o}, 32'd0);
    chk_out("hold_frozen", 1'b1, 32'h4, dat(32'h4));
    stall_i = 1'b0;
    step();
    chk_out("release", 1'b1, 32'h8, dat(32'h8));
    chk("release_req", {31'd0, imem_req_o}, 32'd1);
    chk("release_addr", imem_addr_o, 32'hC);

    // Branch during WAIT while stalled with a valid output
    stall_i = 1'b1;
    imem_gnt_i = 1'b1;
    step();
    imem_gnt_i = 1'b0;
    chk_out("bw_pre", 1'b1, 32'h8, dat(32'h8));
    branch_flag_i = 1'b1;
    branch_target_i = 32'h100;
    step();
    branch_flag_i = 1'b0;
    stall_i = 1'b0;
    chk("bw_valid", {31'd0, inst_valid_o}, 32'd0);
    chk("bw_inst", inst_o, 32'h0);
    chk("bw_req", {31'd0, imem_req_o}, 32'd0);
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = dat(32'hC);
    step();
    imem_rvalid_i = 1'b0;
    chk("bw_drop_valid", {31'd0, inst_valid_o}, 32'd0);
    chk("bw_drop_inst", inst_o, 32'h0);
    chk("bw_req_tgt", {31'd0, imem_req_o}, 32'd1);
    chk("bw_addr_tgt", imem_addr_o, 32'h100);
    do_fetch(32'h100);

    // Branch with simultaneous rvalid
    imem_gnt_i = 1'b1;
    step();
    imem_gnt_i = 1'b0;
    branch_flag_i = 1'b1;
    branch_target_i = 32'h200;
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = dat(32'h104);
    step();
    branch_flag_i = 1'b0;
    imem_rvalid_i = 1'b0;
    chk("bsim_valid", {31'd0, inst_valid_o}, 32'd0);
    chk("bsim_inst", inst_o, 32'h0);
    chk("bsim_req", {31'd0, imem_req_o}, 32'd1);
    chk("bsim_addr", imem_addr_o, 32'h200);

    // Branch in REQ without gnt
    branch_flag_i = 1'b1;
    branch_target_i = 32'h300;
    step();
    branch_flag_i = 1'b0;
    chk("breq_req", {31'd0, imem_req_o}, 32'd1);
    chk("breq_addr", imem_addr_o, 32'h300);
    chk("breq_valid", {31'd0, inst_valid_o}, 32'd0);
    do_fetch(32'h300);

    // Reset while in WAIT; late rvalid must be ignored
    imem_gnt_i = 1'b1;
    step();
    imem_gnt_i = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_out("mrst", 1'b0, 32'h0, 32'h0);
    chk("mrst_req", {31'd0, imem_req_o}, 32'd0);
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = dat(32'h304);
    step();
    chk("mrst_ign_valid", {31'd0, inst_valid_o}, 32'd0);
    chk("mrst_ign_inst", inst_o, 32'h0);
    chk("mrst_req2", {31'd0, imem_req_o}, 32'd1);
    chk("mrst_addr", imem_addr_o, 32'h0);
    step();
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    chk("req_rvalid_ign", {31'd0, inst_valid_o}, 32'd0);
    do_fetch(32'h0);

    // PC wrap
    branch_flag_i = 1'b1;
    branch_target_i = 32'hFFFF_FFFC;
    step();
    branch_flag_i = 1'b0;
    do_fetch(32'hFFFF_FFFC);
    chk("wrap_addr", imem_addr_o, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
